// File: rtl/reg_bank_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_bank_write_arbiter_if
//   Bundles the signals between the two write requesters, the arbiter and the
//   register bank's write port.
//   Requester side (per side x = 0/1):
//     reqx   write request           lockx  keep ownership after this write
//     addrx  target register index   datax  write data
//     gntx   write accepted this cycle (driven by the arbiter)
//   Bank side (driven by the arbiter):
//     WriteEnable  one-hot per-register write enable
//     WriteData    shared data to the bank In inputs
//     err_oor      pulse: accepted write addressed a non-existent register
//   Modports: master = requesters/environment, slave = arbiter.
// -----------------------------------------------------------------------------
interface reg_bank_write_arbiter_if #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
);
  logic                req0;
  logic                lock0;
  logic [ADDR_W-1:0]   addr0;
  logic [DATA_W-1:0]   data0;
  logic                gnt0;

  logic                req1;
  logic                lock1;
  logic [ADDR_W-1:0]   addr1;
  logic [DATA_W-1:0]   data1;
  logic                gnt1;

  logic [NUM_REGS-1:0] WriteEnable;
  logic [DATA_W-1:0]   WriteData;
  logic                err_oor;

  modport master (
    output req0, lock0, addr0, data0,
    output req1, lock1, addr1, data1,
    input  gnt0, gnt1,
    input  WriteEnable, WriteData, err_oor
  );

  modport slave (
    input  req0, lock0, addr0, data0,
    input  req1, lock1, addr1, data1,
    output gnt0, gnt1,
    output WriteEnable, WriteData, err_oor
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_write_arbiter
//   Shares the single write port of a NUM_REGS x DATA_W register bank between
//   requester 0 (pipeline writeback) and requester 1 (memory/fill path).
//   Round-robin arbitration with an optional lock that lets one side own the
//   port for a multi-cycle burst.
//   Grants are combinational from req/lock and the registered state; a write
//   accepted at edge N drives WriteEnable/WriteData between edges N and N+1,
//   so the bank captures it at edge N+1.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous reset, active-low (grants forced low while asserted)
//   bus  reg_bank_write_arbiter_if.slave: requester handshakes + bank write port
// -----------------------------------------------------------------------------
module reg_bank_write_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  reg_bank_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                ptr;        // 0: requester 0 wins a tie, 1: requester 1 wins
  logic                gnt0, gnt1;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_oor;
  logic [NUM_REGS-1:0] sel_onehot;

  logic [NUM_REGS-1:0] we_q;
  logic [DATA_W-1:0]   wd_q;
  logic                err_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Grant logic (outputs). An owner that stops requesting releases the port in
  // the same cycle, so the other side is arbitrated without an idle bubble.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (state == OWN0 && bus.req0) begin
        gnt0 = 1'b1;
      end else if (state == OWN1 && bus.req1) begin
        gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: a granted lock enters (or keeps) ownership; anything else
  // (unlocked final write, owner dropped req, no request) returns to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = IDLE;
    if (gnt0 && bus.lock0)      state_nxt = OWN0;
    else if (gnt1 && bus.lock1) state_nxt = OWN1;
  end

  // ---------------------------------------------------------------------------
  // Write-port mux and address decode. Out-of-range addresses decode to an
  // all-zero enable and raise err_oor instead, so the write is still consumed.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_addr = gnt1 ? bus.addr1 : bus.addr0;
    sel_data = gnt1 ? bus.data1 : bus.data0;
    sel_oor  = (int'(sel_addr) >= NUM_REGS);
    sel_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_onehot[i] = (sel_addr == ADDR_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port and round-robin pointer. The pointer only moves on
  // an accepted write and then favours the side that was not served.
  // ---------------------------------------------------------------------------
  // NOTE: WriteData is reset along with the control flops so the bank input
  // never shows X after reset; there is no storage array here to clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= 1'b0;
      we_q  <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      we_q  <= '0;
      err_q <= 1'b0;
      if (gnt0 || gnt1) begin
        ptr   <= gnt0;
        we_q  <= sel_onehot;
        wd_q  <= sel_data;
        err_q <= sel_oor;
      end
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.WriteEnable = we_q;
  assign bus.WriteData   = wd_q;
  assign bus.err_oor     = err_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_write_arbiter
//   Drives the arbiter with directed scenarios and a long random run, comparing
//   every cycle against a rule-level model: who may be granted, where the
//   accepted write must appear one cycle later, and the final bank contents.
//   The DUT is built with 6 registers on a 3-bit address so addresses 6 and 7
//   exercise the out-of-range path.
// -----------------------------------------------------------------------------
module tb_reg_bank_write_arbiter;
  localparam int NUM_REGS = 6;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_bank_write_arbiter_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bank_write_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: current owner (-1 none), tie-break favourite, the
  // write expected on the bank port this cycle, and the expected bank contents.
  int                  m_owner = -1;
  bit                  m_fav   = 1'b0;
  logic [NUM_REGS-1:0] m_we    = '0;
  logic [DATA_W-1:0]   m_wd    = '0;
  bit                  m_err   = 1'b0;
  bit                  mg0, mg1;
  int                  m_accepts  = 0;
  int                  dut_writes = 0;
  logic [DATA_W-1:0]   m_bank [NUM_REGS];
  logic [DATA_W-1:0]   t_bank [NUM_REGS];   // bank built from DUT outputs
  logic                obs_g0, obs_g1;

  task automatic set0(input bit r, input bit l, input int a, input int d);
    bus.req0 = r; bus.lock0 = l; bus.addr0 = ADDR_W'(a); bus.data0 = DATA_W'(d);
  endtask

  task automatic set1(input bit r, input bit l, input int a, input int d);
    bus.req1 = r; bus.lock1 = l; bus.addr1 = ADDR_W'(a); bus.data1 = DATA_W'(d);
  endtask

  // Who should win this cycle: a requesting owner; else a lone requester;
  // else the favourite.
  task automatic model_grant();
    mg0 = 1'b0;
    mg1 = 1'b0;
    if (m_owner == 0 && bus.req0)      mg0 = 1'b1;
    else if (m_owner == 1 && bus.req1) mg1 = 1'b1;
    else if (bus.req0 && bus.req1)     begin mg0 = !m_fav; mg1 = m_fav; end
    else                               begin mg0 = bus.req0; mg1 = bus.req1; end
  endtask

  // One clock cycle: check at the falling edge, update model at the rising edge.
  task automatic step();
    logic [NUM_REGS-1:0] seen_we;
    logic [DATA_W-1:0]   seen_wd;
    int a, d;
    bit l;
    @(negedge clk);
    model_grant();
    obs_g0 = bus.gnt0;
    obs_g1 = bus.gnt1;
    check("gnt0", bus.gnt0, mg0);
    check("gnt1", bus.gnt1, mg1);
    check("we", bus.WriteEnable, m_we);
    check("wd", bus.WriteData, m_wd);
    check("err", bus.err_oor, m_err);
    check("we_onehot", 32'($countones(bus.WriteEnable) <= 1), 1);
    seen_we = bus.WriteEnable;
    seen_wd = bus.WriteData;
    if (seen_we != '0 || bus.err_oor) dut_writes++;
    @(posedge clk);
    for (int i = 0; i < NUM_REGS; i++) if (seen_we[i]) t_bank[i] = seen_wd;
    m_we  = '0;
    m_err = 1'b0;
    if (mg0 || mg1) begin
      a = mg0 ? int'(bus.addr0) : int'(bus.addr1);
      d = mg0 ? int'(bus.data0) : int'(bus.data1);
      l = mg0 ? bus.lock0 : bus.lock1;
      m_accepts++;
      m_fav   = mg0;
      m_owner = l ? (mg0 ? 0 : 1) : -1;
      m_wd    = DATA_W'(d);
      if (a < NUM_REGS) begin
        m_we      = NUM_REGS'(1) << a;
        m_bank[a] = DATA_W'(d);
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_owner = -1;
    end
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_we", bus.WriteEnable, 0);
    check("rst_wd", bus.WriteData, 0);
    check("rst_err", bus.err_oor, 0);
    m_owner = -1; m_fav = 1'b0; m_we = '0; m_wd = '0; m_err = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    for (int i = 0; i < NUM_REGS; i++) begin m_bank[i] = '0; t_bank[i] = '0; end
    @(posedge clk); #1;
    do_reset();

    // 1: single write to register 3
    set0(1, 0, 3, 8'hA5);
    step();
    check("t1_gnt0", obs_g0, 1);
    check("t1_we", bus.WriteEnable, 6'b001000);
    check("t1_wd", bus.WriteData, 8'hA5);
    set0(0, 0, 0, 0);
    step();
    check("t1_bank3", t_bank[3], 8'hA5);
    check("t1_we_off", bus.WriteEnable, 0);

    // 2: both requesting after reset alternate 0,1,0,1
    @(posedge clk); #1;
    do_reset();
    set0(1, 0, 1, 8'h11);
    set1(1, 0, 2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_gnt0", obs_g0, (i % 2 == 0) ? 1 : 0);
      check("t2_gnt1", obs_g1, (i % 2 == 1) ? 1 : 0);
    end

    // 3: locked burst of three by requester 0 holds off requester 1
    set0(1, 1, 4, 8'h40);
    set1(1, 0, 5, 8'h50);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.lock0 = 1'b0;
      bus.data0 = DATA_W'(8'h40 + i);
      step();
      check("t3_gnt0", obs_g0, (i < 3) ? 1 : 0);
      check("t3_gnt1", obs_g1, (i == 3) ? 1 : 0);
    end
    step();
    check("t3_idle_gnt0", obs_g0, 1);

    // 4: out-of-range write is consumed and flagged for exactly one cycle
    set0(0, 0, 0, 0);
    set1(1, 0, 7, 8'h3C);
    step();
    check("t4_gnt1", obs_g1, 1);
    check("t4_we", bus.WriteEnable, 0);
    check("t4_err", bus.err_oor, 1);
    check("t4_wd", bus.WriteData, 8'h3C);
    set1(0, 0, 0, 0);
    step();
    check("t4_err_off", bus.err_oor, 0);

    // 5: reset in the middle of a requester-1 burst, in-range and out-of-range
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      do_reset();
      set0(0, 0, 0, 0);
      set1(1, 1, (k == 0) ? 2 : 7, 8'h77);
      step();
      step();
      check("t5_pending", 32'((bus.WriteEnable != '0) || bus.err_oor), 1);
      set0(1, 0, 1, 8'h99);
      do_reset();
      bus.lock1 = 1'b0;
      step();
      check("t5_first_gnt0", obs_g0, 1);
    end

    // 6: random traffic; requests hold until accepted
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    step();
    for (int i = 0; i < NUM_REGS; i++) begin m_bank[i] = '0; t_bank[i] = '0; end
    m_accepts  = 0;
    dut_writes = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!(bus.req0 && !mg0))
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      if (!(bus.req1 && !mg1))
        set1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      step();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    check("rand_write_count", dut_writes, m_accepts);
    for (int i = 0; i < NUM_REGS; i++) check("rand_bank", t_bank[i], m_bank[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
